// File: rtl/axis_pipeline_chain_if.sv
// AXI-Stream link carrying tdata/tlast with valid/ready handshake.
// master drives payload and valid; slave drives ready.
interface axis_pipeline_chain_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_pipeline_chain.sv
// AXI-Stream register chain, DEPTH stages: MODE 0 wire, 1 forward-registered, 2 skid; optional occ count via AXIS_PIPELINE_CHAIN_OCC_EN.
// Latency: DEPTH cycles in MODE 1/2, 0 in MODE 0; full 1 beat/clk throughput in every mode.
// Backpressure: MODE 1 ready is combinational through all stages; MODE 2 ready is a flop (first-stage skid empty).
module axis_pipeline_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int MODE  = 2,
    localparam int OCC_W = $clog2(2*DEPTH+1)
) (
    input  logic clk,
    input  logic rst,
    axis_pipeline_chain_if.slave  s_rx,
    axis_pipeline_chain_if.master m_tx
`ifdef AXIS_PIPELINE_CHAIN_OCC_EN
    ,
    output logic [OCC_W-1:0] occ
`endif
);

    localparam int PW = WIDTH + 1;

    generate
        if (MODE == 0) begin : g_pass
            assign m_tx.tdata  = s_rx.tdata;
            assign m_tx.tlast  = s_rx.tlast;
            assign m_tx.tvalid = s_rx.tvalid;
            assign s_rx.tready = m_tx.tready;
        end else begin : g_chain
            // Link i feeds stage i; link DEPTH is the downstream port.
            logic [PW-1:0] pl [DEPTH+1];
            logic [DEPTH:0] vld;
            logic [DEPTH:0] rdy;

            assign pl[0]  = {s_rx.tlast, s_rx.tdata};
            assign vld[0] = s_rx.tvalid;

            for (genvar i = 0; i < DEPTH; i++) begin : g_stage
                if (MODE == 1) begin : g_fwd
                    logic [PW-1:0] d_q;
                    logic          v_q;
                    logic          in_x;

                    assign in_x = vld[i] & rdy[i];

                    always_ff @(posedge clk) begin
                        if (rst)
                            v_q <= 1'b0;
                        else if (in_x)
                            v_q <= 1'b1;
                        else if (rdy[i+1])
                            v_q <= 1'b0;
                    end

                    always_ff @(posedge clk) begin
                        if (in_x)
                            d_q <= pl[i];
                    end

                    assign vld[i+1] = v_q;
                    assign pl[i+1]  = d_q;
                end else begin : g_skid
                    logic [PW-1:0] m_d;
                    logic [PW-1:0] k_d;
                    logic          m_v;
                    logic          k_v;
                    logic          in_x;
                    logic          drain;

                    assign in_x  = vld[i] & ~k_v;
                    assign drain = m_v & rdy[i+1];

                    // Skid only fills when main is stuck; it empties into main on the next drain.
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            m_v <= 1'b0;
                            k_v <= 1'b0;
                        end else if (k_v) begin
                            if (drain)
                                k_v <= 1'b0;
                        end else if (in_x) begin
                            if (m_v & ~drain)
                                k_v <= 1'b1;
                            else
                                m_v <= 1'b1;
                        end else if (drain) begin
                            m_v <= 1'b0;
                        end
                    end

                    always_ff @(posedge clk) begin
                        if (k_v & drain)
                            m_d <= k_d;
                        else if (in_x & (~m_v | drain))
                            m_d <= pl[i];
                        if (in_x & m_v & ~drain)
                            k_d <= pl[i];
                    end

                    assign rdy[i]   = ~k_v;
                    assign vld[i+1] = m_v;
                    assign pl[i+1]  = m_d;
                end
            end

            if (MODE == 1) begin : g_fwd_rdy
                always_comb begin
                    rdy[DEPTH] = m_tx.tready;
                    for (int j = DEPTH - 1; j >= 0; j--)
                        rdy[j] = ~vld[j+1] | rdy[j+1];
                end
            end else begin : g_skid_rdy
                assign rdy[DEPTH] = m_tx.tready;
            end

            // Gating with rst keeps both handshakes idle while state is being flushed.
            assign s_rx.tready = rdy[0] & ~rst;
            assign m_tx.tvalid = vld[DEPTH] & ~rst;
            assign {m_tx.tlast, m_tx.tdata} = pl[DEPTH];
        end
    endgenerate

`ifdef AXIS_PIPELINE_CHAIN_OCC_EN
    generate
        if (MODE == 0) begin : g_occ_none
            assign occ = '0;
        end else begin : g_occ
            logic [OCC_W-1:0] cnt;
            logic             in_x;
            logic             out_x;

            assign in_x  = s_rx.tvalid & s_rx.tready;
            assign out_x = m_tx.tvalid & m_tx.tready;

            always_ff @(posedge clk) begin
                if (rst)
                    cnt <= '0;
                else if (in_x & ~out_x)
                    cnt <= cnt + OCC_W'(1);
                else if (~in_x & out_x)
                    cnt <= cnt - OCC_W'(1);
            end

            assign occ = cnt;
        end
    endgenerate
`endif

endmodule
